// File: rtl/serial2tcp_arbiter.sv
// serial2tcp_arbiter
// Round-robin arbiter sharing one byte-stream sink between NUM_CH requesters.
// Each grant is a burst: one header byte (8'hC0 | channel) followed by data
// bytes until the requester's last flag or MAX_BURST data bytes.
//
// Ports:
//   sys_clk, sys_rst_n       clock, synchronous active-low reset
//   req_valid/ready/last     per-channel handshake and end-of-packet flag
//   req_data                 per-channel byte, channel i at [8i+7:8i]
//   source_valid/ready       output handshake toward the serial2tcp sink
//   source_data/last         output byte, last byte of the current burst
//
// state  | meaning
// IDLE   | no grant; pick next requester round-robin from rr_ptr+1
// HEADER | presenting channel header byte 8'hC0 | grant
// DATA   | pass-through of granted channel until last or burst cap
module serial2tcp_arbiter #(
    parameter int NUM_CH    = 2,
    parameter int MAX_BURST = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic [NUM_CH-1:0]     req_valid,
    output logic [NUM_CH-1:0]     req_ready,
    input  logic [8*NUM_CH-1:0]   req_data,
    input  logic [NUM_CH-1:0]     req_last,
    output logic                  source_valid,
    input  logic                  source_ready,
    output logic [7:0]            source_data,
    output logic                  source_last
);

    typedef enum logic [1:0] {S_IDLE, S_HEADER, S_DATA} state_t;

    state_t     state;
    logic [1:0] grant;
    logic [1:0] rr_ptr;
    logic [7:0] count;

    // Channels padded to four so a 2-bit grant indexes without width games.
    logic [3:0] valid_pad;
    logic [3:0] last_pad;
    logic [7:0] data_arr [4];
    logic [1:0] pick;
    logic [1:0] scan_idx;
    logic       any_valid;
    logic       at_cap;
    logic       xfer;

    assign valid_pad = 4'(req_valid);
    assign last_pad  = 4'(req_last);
    assign any_valid = |req_valid;
    assign at_cap    = (count == 8'(MAX_BURST - 1));
    assign xfer      = source_valid & source_ready;

    always_comb begin
        for (int i = 0; i < 4; i++) data_arr[i] = 8'h00;
        for (int i = 0; i < NUM_CH; i++) data_arr[i] = req_data[8*i +: 8];
    end

    // Scan from farthest to nearest so the channel closest after rr_ptr wins.
    always_comb begin
        pick     = 2'd0;
        scan_idx = 2'd0;
        for (int k = NUM_CH; k >= 1; k--) begin
            scan_idx = 2'((int'(rr_ptr) + k) % NUM_CH);
            if (valid_pad[scan_idx]) pick = scan_idx;
        end
    end

    always_comb begin
        source_valid = 1'b0;
        source_data  = 8'h00;
        source_last  = 1'b0;
        case (state)
            S_HEADER: begin
                source_valid = 1'b1;
                source_data  = 8'hC0 | {6'd0, grant};
            end
            S_DATA: begin
                source_valid = valid_pad[grant];
                source_data  = data_arr[grant];
                source_last  = valid_pad[grant] & (last_pad[grant] | at_cap);
            end
            default: ;
        endcase
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (state == S_DATA && grant == 2'(i)) req_ready[i] = source_ready;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state  <= S_IDLE;
            grant  <= 2'd0;
            rr_ptr <= 2'(NUM_CH - 1);
            count  <= 8'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (any_valid) begin
                        grant <= pick;
                        count <= 8'd0;
                        state <= S_HEADER;
                    end
                end
                S_HEADER: begin
                    if (xfer) state <= S_DATA;
                end
                S_DATA: begin
                    if (xfer) begin
                        count <= count + 8'd1;
                        if (source_last) begin
                            state  <= S_IDLE;
                            rr_ptr <= grant;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial2tcp_arbiter.sv
// Testbench for serial2tcp_arbiter (NUM_CH=2, MAX_BURST=4).
// Stimulus pushes hand-computed expected beats into exp_q; a monitor pops
// and compares on every output transfer.
module tb_serial2tcp_arbiter;

    localparam int NUM_CH    = 2;
    localparam int MAX_BURST = 4;

    logic                sys_clk = 1'b0;
    logic                sys_rst_n = 1'b0;
    logic [NUM_CH-1:0]   req_valid;
    logic [NUM_CH-1:0]   req_ready;
    logic [8*NUM_CH-1:0] req_data;
    logic [NUM_CH-1:0]   req_last;
    logic                source_valid;
    logic                source_ready;
    logic [7:0]          source_data;
    logic                source_last;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q [$];
    logic [8:0] ch_q [2][$];
    bit         gap_en = 1'b0;

    serial2tcp_arbiter #(.NUM_CH(NUM_CH), .MAX_BURST(MAX_BURST)) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_data     (req_data),
        .req_last     (req_last),
        .source_valid (source_valid),
        .source_ready (source_ready),
        .source_data  (source_data),
        .source_last  (source_last)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic l, input logic [7:0] d);
        exp_q.push_back({l, d});
    endtask

    task automatic push_ch(input int ch, input logic [7:0] d, input logic l);
        ch_q[ch].push_back({l, d});
    endtask

    // Requester model: holds valid until accepted; optional one-cycle gap
    // after an accepted byte.
    initial begin : drv
        logic [1:0] xf;
        logic [8:0] fr;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        forever begin
            @(negedge sys_clk);
            xf = req_valid & req_ready & {2{sys_rst_n}};
            @(posedge sys_clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (xf[i]) void'(ch_q[i].pop_front());
                if (req_valid[i] && !xf[i]) begin
                    // hold current byte
                end else if (ch_q[i].size() > 0 &&
                             !(gap_en && xf[i] && $urandom_range(0, 2) == 0)) begin
                    fr = ch_q[i][0];
                    req_valid[i]      = 1'b1;
                    req_data[8*i +: 8] = fr[7:0];
                    req_last[i]       = fr[8];
                end else begin
                    req_valid[i]      = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i]       = 1'b0;
                end
            end
        end
    end

    initial begin : mon
        logic [8:0] e;
        logic [9:0] prev_out;
        bit         prev_stall;
        bit         prev_last;
        prev_stall = 1'b0;
        prev_last  = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge sys_clk);
            if (sys_rst_n) begin
                if (prev_last) begin
                    total++;
                    if (source_valid !== 1'b0) begin
                        bad++;
                        $display("FAIL bubble: got valid=%0b want 0", source_valid);
                    end
                end
                if (prev_stall) begin
                    total++;
                    if ({source_valid, source_last, source_data} !== prev_out) begin
                        bad++;
                        $display("FAIL stall_hold: got %0h want %0h",
                                 {source_valid, source_last, source_data}, prev_out);
                    end
                end
                if (req_ready != '0) begin
                    total++;
                    if ($countones(req_ready) != 1) begin
                        bad++;
                        $display("FAIL ready_onehot: got %b want one-hot", req_ready);
                    end
                end
                if (source_valid && source_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL extra_beat: got last=%0b data=%02h want none",
                                 source_last, source_data);
                    end else begin
                        e = exp_q.pop_front();
                        if ({source_last, source_data} !== e) begin
                            bad++;
                            $display("FAIL beat: got last=%0b data=%02h want last=%0b data=%02h",
                                     source_last, source_data, e[8], e[7:0]);
                        end
                    end
                end
            end
            prev_last  = sys_rst_n && source_valid && source_ready && source_last;
            prev_stall = sys_rst_n && source_valid && !source_ready;
            prev_out   = {source_valid, source_last, source_data};
        end
    end

    task automatic do_reset();
        sys_rst_n    = 1'b0;
        source_ready = 1'b0;
        gap_en       = 1'b0;
        @(posedge sys_clk);
        @(posedge sys_clk);
        #1;
        sys_rst_n    = 1'b1;
        source_ready = 1'b1;
    endtask

    task automatic wait_drain(input bit rand_ready, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || ch_q[0].size() != 0 || ch_q[1].size() != 0) && n < budget) begin
            @(posedge sys_clk);
            #1;
            if (rand_ready) source_ready = 1'($urandom_range(0, 1));
            n++;
        end
        total++;
        if (exp_q.size() != 0 || ch_q[0].size() != 0 || ch_q[1].size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d beats pending want 0", exp_q.size());
        end
        source_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
    endtask

    initial begin : main
        int n;
        source_ready = 1'b0;

        // Reset state
        do_reset();
        @(negedge sys_clk);
        check("rst_valid", 32'(source_valid), 32'd0);
        check("rst_last",  32'(source_last),  32'd0);
        check("rst_ready", 32'(req_ready),    32'd0);
        check("rst_data",  32'(source_data),  32'd0);

        // Single channel
        push_exp(0, 8'hC0); push_exp(0, 8'h11); push_exp(0, 8'h22); push_exp(1, 8'h33);
        push_ch(0, 8'h11, 0); push_ch(0, 8'h22, 0); push_ch(0, 8'h33, 1);
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!req_valid[0] && n < 10);
        check("hdr_latency_idle", 32'(source_valid), 32'd0);
        @(negedge sys_clk);
        check("hdr_latency_valid", 32'(source_valid), 32'd1);
        check("hdr_latency_data",  32'(source_data),  32'hC0);
        wait_drain(0, 200);

        // Contention, 2-byte packets on both channels
        do_reset();
        push_exp(0, 8'hC0); push_exp(0, 8'hA1); push_exp(1, 8'hA2);
        push_exp(0, 8'hC1); push_exp(0, 8'hB1); push_exp(1, 8'hB2);
        push_exp(0, 8'hC0); push_exp(0, 8'hA3); push_exp(1, 8'hA4);
        push_exp(0, 8'hC1); push_exp(0, 8'hB3); push_exp(1, 8'hB4);
        push_ch(0, 8'hA1, 0); push_ch(0, 8'hA2, 1); push_ch(0, 8'hA3, 0); push_ch(0, 8'hA4, 1);
        push_ch(1, 8'hB1, 0); push_ch(1, 8'hB2, 1); push_ch(1, 8'hB3, 0); push_ch(1, 8'hB4, 1);
        wait_drain(0, 300);

        // Burst cap: 6 bytes split 4+2, then last on exactly the 4th byte
        do_reset();
        push_exp(0, 8'hC1); push_exp(0, 8'h01); push_exp(0, 8'h02); push_exp(0, 8'h03); push_exp(1, 8'h04);
        push_exp(0, 8'hC1); push_exp(0, 8'h05); push_exp(1, 8'h06);
        for (int i = 1; i <= 6; i++) push_ch(1, 8'(i), 1'(i == 6));
        wait_drain(0, 300);
        push_exp(0, 8'hC0); push_exp(0, 8'h41); push_exp(0, 8'h42); push_exp(0, 8'h43); push_exp(1, 8'h44);
        for (int i = 1; i <= 4; i++) push_ch(0, 8'(8'h40 + i), 1'(i == 4));
        wait_drain(0, 300);

        // Backpressure and requester gaps
        do_reset();
        gap_en = 1'b1;
        push_exp(0, 8'hC0); push_exp(0, 8'h61); push_exp(0, 8'h62); push_exp(0, 8'h63); push_exp(1, 8'h64);
        push_exp(0, 8'hC1); push_exp(0, 8'h71); push_exp(0, 8'h72); push_exp(1, 8'h73);
        push_exp(0, 8'hC0); push_exp(1, 8'h65);
        for (int i = 1; i <= 5; i++) push_ch(0, 8'(8'h60 + i), 1'(i == 5));
        for (int i = 1; i <= 3; i++) push_ch(1, 8'(8'h70 + i), 1'(i == 3));
        wait_drain(1, 600);
        gap_en = 1'b0;

        // Reset mid-burst after two data bytes
        do_reset();
        push_exp(0, 8'hC0); push_exp(0, 8'h51); push_exp(0, 8'h52);
        push_exp(0, 8'hC0); push_exp(0, 8'h53); push_exp(1, 8'h54);
        for (int i = 1; i <= 4; i++) push_ch(0, 8'(8'h50 + i), 1'(i == 4));
        n = 0;
        do begin
            @(negedge sys_clk);
            n++;
        end while (!(source_valid && source_ready && source_data == 8'h52) && n < 50);
        @(posedge sys_clk);
        #1;
        source_ready = 1'b0;
        sys_rst_n    = 1'b0;
        @(posedge sys_clk);
        #1;
        sys_rst_n    = 1'b1;
        source_ready = 1'b1;
        @(negedge sys_clk);
        check("rst_abort_valid", 32'(source_valid), 32'd0);
        @(negedge sys_clk);
        check("rst_new_hdr_valid", 32'(source_valid), 32'd1);
        check("rst_new_hdr_data",  32'(source_data),  32'hC0);
        wait_drain(0, 200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/serial2tcp_arbiter.md
# serial2tcp_arbiter

Round-robin arbiter that shares the single serial2tcp byte-stream sink (the TCP bridge input) between several independent byte-stream requesters. Each grant is a burst. The burst is preceded by one channel header byte and ends on the requester's `last` flag or on a maximum burst length. The host side can demultiplex the channels from the header bytes.

## Interface
Parameters:
- `NUM_CH`, default 2: number of requesters, legal range 1..4.
- `MAX_BURST`, default 16: maximum data bytes per grant, legal range 1..255.

Ports:
- `sys_clk`, in, 1: single clock, rising edge.
- `sys_rst_n`, in, 1: reset, synchronous, active-low.
- `req_valid`, in, NUM_CH: per-channel byte valid.
- `req_ready`, out, NUM_CH: per-channel byte accept.
- `req_data`, in, 8*NUM_CH: per-channel byte; channel i occupies bits [8i+7:8i].
- `req_last`, in, NUM_CH: per-channel end-of-packet flag, qualified by valid.
- `source_valid`, out, 1: output byte valid, toward the serial2tcp sink.
- `source_ready`, in, 1: output byte accept.
- `source_data`, out, 8: output byte.
- `source_last`, out, 1: final byte of the current burst.

## Operation
- A beat transfers on any cycle where valid and ready are both high. This holds on every interface.
- The FSM has three states: IDLE, HEADER, DATA. Registered state: `grant` (2 bits), `rr_ptr` (2 bits), `count` (8 bits).
- **IDLE**
  - `source_valid`=0 and all `req_ready`=0.
  - If any `req_valid` is high, `grant` takes the first channel with valid set, searching from `rr_ptr`+1 upward, modulo NUM_CH. The state moves to HEADER and `count` is set to 0.
- **HEADER**
  - `source_valid`=1, `source_data`=8'hC0 | grant, `source_last`=0.
  - The state moves to DATA on the transfer. Valid holds until the transfer; holding does not depend on `req_valid`.
- **DATA**
  - Combinational pass-through of the granted channel: `source_valid`=`req_valid[grant]`, `source_data`=`req_data[grant]`, `req_ready[grant]`=`source_ready`.
  - All non-granted `req_ready` bits are 0.
  - `source_last` = `req_valid[grant]` & (`req_last[grant]` | `count`==MAX_BURST-1).
  - On each transfer, `count` increments.
  - On a transfer with `source_last` high, the state moves to IDLE and `rr_ptr` is set to `grant`.
- The grant is locked for the whole burst. There is no timeout and no preemption. If the granted requester deasserts valid mid-burst, the arbiter waits with `source_valid`=0.
- The arbiter never drops or duplicates bytes. Byte order within a channel is preserved.
- With NUM_CH=1 the pointer logic degenerates: grant is always 0.

## Timing
- Reset, on the rising edge with `sys_rst_n`=0:
  - State resets to IDLE, `count` to 0, `grant` to 0, and `rr_ptr` to NUM_CH-1 so that channel 0 wins first.
  - From the next cycle, `source_valid`=0, `source_last`=0, `req_ready`=0, and `source_data`=0. `source_data` is driven to 0 in IDLE.
- Reset asserted mid-burst aborts the burst immediately. The next cycle is IDLE with valid low. A new burst starts with a fresh header.
- Request to header latency: valid seen in IDLE at cycle N gives the header on `source_valid` at cycle N+1. The first data byte can transfer at N+2 at the earliest.
- There is one IDLE bubble cycle between consecutive bursts, including back-to-back bursts from the same channel.
- Simultaneous requests are served round-robin in strict rotation from `rr_ptr`+1. A channel that just finished has lowest priority.
- `req_last` on the MAX_BURST-th byte ends the burst once, not twice.
- A burst that ends by hitting MAX_BURST without `req_last` resumes in a later grant with a new header.
- MAX_BURST=1 gives exactly one data byte per header.
- A `source_ready` stall in HEADER or DATA holds every output stable.

## Test plan
- **Single channel:** after reset, ch0 sends bytes 0x11,0x22,0x33 with last on 0x33. `source_ready`=1 throughout.
  - Required output: 0xC0,0x11,0x22,0x33, with `source_last` only on 0x33.
  - The header appears 1 cycle after `req_valid` rises.
- **Contention:** ch0 and ch1 both request continuously, each with 2-byte packets.
  - Required output order: 0xC0,a,b, bubble, 0xC1,c,d, bubble, 0xC0,...
  - `req_ready[1]` stays 0 during ch0's burst.
- **Burst cap:** MAX_BURST=4, ch1 sends 6 bytes 0x01..0x06 with last on 0x06.
  - Required output: 0xC1,01,02,03,04 with last on 04, then 0xC1,05,06 with last on 06.
- **Backpressure and gaps:** random `source_ready` and random `req_valid` gaps on the granted channel.
  - Byte stream, headers and last flags match a reference scoreboard.
  - No output change while stalled.
- **Reset mid-burst:** assert `sys_rst_n`=0 for one cycle after 2 data bytes of a burst.
  - Next cycle: `source_valid`=0.
  - The next request produces a new 0xC0 header from ch0, not a continuation of the aborted burst.
